lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_step.sv | 11 +
 rtl/lfsr_checker.sv | 130 +++++++++++++
 tb/tb_lfsr_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: word width, Fibonacci tap mask, step function and
// checker state type. Used by both the generator side and lfsr_checker.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  // Taps 15,13,12,10 feed the new LSB; matches the generator bit for bit.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ^(x & TAP_MASK)};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of the 16-bit Fibonacci LFSR.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = lfsr_next(cur);

endmodule

// File: rtl/lfsr_checker.sv
// LFSR sequence checker: hunts, syncs and locks onto a 16-bit Fibonacci LFSR
// stream. The error counter is built only when LFSR_CHECKER_ERRCNT_EN is defined.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       rand_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

  state_t            state, state_next;
  logic [LFSR_W-1:0] ref_word, ref_next, step_out;
  logic [3:0]        match_cnt, match_next, match_inc;
  logic [3:0]        miss_cnt, miss_next, miss_inc;
  logic              pulse_next;
  logic              err_inc;
  logic              is_match, is_zero;

  lfsr_step u_step (
    .cur (ref_word),
    .nxt (step_out)
  );

  assign is_match  = (rand_in == step_out);
  assign is_zero   = (rand_in == '0);
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;

  // In LOCKED a mismatch flywheels ref forward so one bad word does not
  // desynchronise the checker from an otherwise healthy stream.
  always_comb begin
    state_next = state;
    ref_next   = ref_word;
    match_next = match_cnt;
    miss_next  = miss_cnt;
    pulse_next = 1'b0;
    err_inc    = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (!is_zero) begin
            ref_next   = rand_in;
            match_next = '0;
            state_next = SYNC;
          end
        end
        SYNC: begin
          if (is_match) begin
            ref_next   = rand_in;
            match_next = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_next = LOCKED;
              miss_next  = '0;
            end
          end else if (!is_zero) begin
            ref_next   = rand_in;
            match_next = '0;
          end else begin
            state_next = HUNT;
          end
        end
        LOCKED: begin
          if (is_match) begin
            ref_next  = rand_in;
            miss_next = '0;
          end else begin
            ref_next   = step_out;
            miss_next  = miss_inc;
            pulse_next = 1'b1;
            err_inc    = 1'b1;
            if (miss_inc == LOSS_TGT) state_next = HUNT;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      ref_word  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      ref_word  <= ref_next;
      match_cnt <= match_next;
      miss_cnt  <= miss_next;
      locked    <= (state_next == LOCKED);
      err_pulse <= pulse_next;
    end
  end

`ifdef LFSR_CHECKER_ERRCNT_EN
  logic [ERR_W-1:0] err_q;

  // Clear has priority over a same-cycle increment; count saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (clr_err) begin
      err_q <= '0;
    end else if (err_inc && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_count = err_q;
`else
  logic unused_errcnt;
  assign unused_errcnt = &{1'b0, clr_err, err_inc};
  assign err_count     = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus pushes expected outputs, a
// monitor pops and compares on each falling edge. Honours LFSR_CHECKER_ERRCNT_EN.
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] rand_in;
  logic        clr_err;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  typedef struct {
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          vec_id     = 0;
  logic [15:0] cur;

  lfsr_checker #(
    .LOCK_CNT (4),
    .LOSS_CNT (3),
    .ERR_W    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rand_in   (rand_in),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] gen_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [15:0] cnt_of(input int n);
`ifdef LFSR_CHECKER_ERRCNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic clr,
                               input logic el, input logic ep, input int ecnt);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    rand_in  = w;
    clr_err  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
    e.locked = el;
    e.pulse  = ep;
    e.cnt    = cnt_of(ecnt);
    e.id     = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  task automatic sendGood(input logic el, input int ecnt);
    applyStimulus(1'b1, cur, 1'b0, el, 1'b0, ecnt);
    cur = gen_next(cur);
  endtask

  task automatic sendBad(input logic el, input int ecnt);
    applyStimulus(1'b1, cur ^ 16'h0001, 1'b0, el, 1'b1, ecnt);
    cur = gen_next(cur);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput($sformatf("v%0d.locked", e.id), {15'd0, locked}, {15'd0, e.locked});
        checkOutput($sformatf("v%0d.err_pulse", e.id), {15'd0, err_pulse}, {15'd0, e.pulse});
        checkOutput($sformatf("v%0d.err_count", e.id), err_count, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    rand_in  = 16'h0000;
    clr_err  = 1'b0;
    #3;
    checkOutput("reset.locked", {15'd0, locked}, 16'd0);
    checkOutput("reset.err_pulse", {15'd0, err_pulse}, 16'd0);
    checkOutput("reset.err_count", err_count, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Zero word in HUNT is ignored, then the hand-computed stream locks on word 5.
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16'hACE1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16'h59C3, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16'hB387, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16'h670F, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16'hCE1E, 1'b0, 1'b1, 1'b0, 0);
    cur = gen_next(16'hCE1E);

    // Single corrupted word while locked.
    sendBad(1'b1, 1);
    sendGood(1'b1, 1);
    sendGood(1'b1, 1);

    // Idle gap with garbage on the bus, then resume.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 16'hFFFF ^ 16'(i), 1'b0, 1'b1, 1'b0, 1);
    sendGood(1'b1, 1);
    sendGood(1'b1, 1);

    // Zero word while locked is a mismatch.
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2);
    cur = gen_next(cur);
    sendGood(1'b1, 2);

    // Clear collides with a mismatch: clear wins, pulse still fires.
    applyStimulus(1'b1, cur ^ 16'h0001, 1'b1, 1'b1, 1'b1, 0);
    cur = gen_next(cur);
    sendGood(1'b1, 0);

    // Three misses drop lock; count frozen while re-acquiring.
    sendBad(1'b1, 1);
    sendBad(1'b1, 2);
    sendBad(1'b0, 3);
    for (int i = 0; i < 4; i++) sendGood(1'b0, 3);
    sendGood(1'b1, 3);
    applyStimulus(1'b1, cur, 1'b1, 1'b1, 1'b0, 0);
    cur = gen_next(cur);
    sendBad(1'b1, 1);

    // Asynchronous reset in mid-lock.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset.locked", {15'd0, locked}, 16'd0);
    checkOutput("midreset.err_pulse", {15'd0, err_pulse}, 16'd0);
    checkOutput("midreset.err_count", err_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Re-acquire with a SYNC restart on an unrelated nonzero word.
    sendGood(1'b0, 0);
    sendGood(1'b0, 0);
    cur = 16'h1234;
    sendGood(1'b0, 0);
    for (int i = 0; i < 3; i++) sendGood(1'b0, 0);
    sendGood(1'b1, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations pending, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
